// File: rtl/vga_text_console_pkg.sv
// Shared constants, character codes and state encodings for the VGA text console writer.
// Screen is COLS x ROWS glyph bytes packed four per 32-bit VRAM word.
package vga_text_console_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int WORDS     = ROWS * COLS / 4;
  localparam int ROW_WORDS = COLS / 4;

  localparam logic [7:0]  BLANK_CODE = 8'h00;
  localparam logic [31:0] BLANK_WORD = {4{BLANK_CODE}};

  localparam logic [6:0] LAST_COL    = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);
  localparam logic [9:0] LAST_WORD   = 10'(WORDS - 1);
  localparam logic [9:0] SCROLL_LAST = 10'(WORDS - ROW_WORDS - 1);
  localparam logic [9:0] CLR_FIRST   = 10'(WORDS - ROW_WORDS);
  localparam logic [9:0] ROW_WORDS_W = 10'(ROW_WORDS);

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CHAR,
    ST_SC_RD,
    ST_SC_RDW,
    ST_SC_WR,
    ST_SC_CLR,
    ST_CLR
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_RETURN,
    CUR_BACK,
    CUR_HOME
  } cursor_op_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor position registers; the row saturates at the last row and overflow tells the
// FSM that the requested move needs a hardware scroll.
module console_cursor
  import vga_text_console_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  cursor_op_t op,
  output logic [6:0] col,
  output logic [4:0] row,
  output logic       overflow
);

  assign overflow = (row == LAST_ROW) &&
                    ((op == CUR_NEWLINE) || ((op == CUR_ADVANCE) && (col == LAST_COL)));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      col <= '0;
      row <= '0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row != LAST_ROW) row <= row + 5'd1;
          end else begin
            col <= col + 7'd1;
          end
        end
        CUR_NEWLINE: begin
          col <= '0;
          if (row != LAST_ROW) row <= row + 5'd1;
        end
        CUR_RETURN: col <= '0;
        CUR_BACK:   if (col != '0) col <= col - 7'd1;
        CUR_HOME: begin
          col <= '0;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_text_console_writer.sv
// Avalon-MM master that turns a cp437 byte stream into VRAM glyph writes, handling
// LF/CR/BS/FF and scrolling the whole screen up one row when the cursor runs off the bottom.
module vga_text_console_writer
  import vga_text_console_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  input  logic [7:0]  CHAR_DATA,
  output logic [9:0]  AVM_ADDR,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST,
  input  logic        AVM_READDATAVALID,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);

  state_t      state, state_nxt;
  cursor_op_t  cur_op;
  logic        overflow;
  logic        accept;
  logic        is_move;
  logic [6:0]  code;
  logic [11:0] cell_idx;
  logic [9:0]  word, word_nxt, addr_nxt;
  logic        read_nxt, write_nxt;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;

  assign accept     = CHAR_VALID && (state == ST_IDLE);
  assign code       = CHAR_DATA[6:0];
  assign is_move    = (code == CH_LF) || (code == CH_CR) || (code == CH_BS);
  assign cell_idx   = 12'(CURSOR_ROW) * 12'(COLS) + 12'(CURSOR_COL);
  assign CHAR_READY = (state == ST_IDLE) && !RESET;
  assign BUSY       = (state != ST_IDLE);

  console_cursor u_cursor (
    .CLK      (CLK),
    .RESET    (RESET),
    .op       (cur_op),
    .col      (CURSOR_COL),
    .row      (CURSOR_ROW),
    .overflow (overflow)
  );

  // Cursor moves are decided apart from the output logic, which consumes the overflow result.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    cur_op = CUR_HOLD;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (code)
            CH_LF:   cur_op = CUR_NEWLINE;
            CH_CR:   cur_op = CUR_RETURN;
            CH_BS:   cur_op = CUR_BACK;
            default: ;
          endcase
        end
      end
      ST_WR_CHAR: if (!AVM_WAITREQUEST) cur_op = CUR_ADVANCE;
      ST_CLR:     if (!AVM_WAITREQUEST && (word == LAST_WORD)) cur_op = CUR_HOME;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (code == CH_FF)  state_nxt = ST_CLR;
          else if (overflow)  state_nxt = ST_SC_RD;
          else if (!is_move)  state_nxt = ST_WR_CHAR;
        end
      end
      ST_WR_CHAR: if (!AVM_WAITREQUEST) state_nxt = overflow ? ST_SC_RD : ST_IDLE;
      ST_SC_RD:   if (!AVM_WAITREQUEST) state_nxt = ST_SC_RDW;
      ST_SC_RDW:  if (AVM_READDATAVALID) state_nxt = ST_SC_WR;
      ST_SC_WR: begin
        if (!AVM_WAITREQUEST) state_nxt = (word == SCROLL_LAST) ? ST_SC_CLR : ST_SC_RD;
      end
      ST_SC_CLR, ST_CLR: begin
        if (!AVM_WAITREQUEST && (word == LAST_WORD)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered Avalon outputs; holding is the default, which covers stalls.
  always_comb begin
    read_nxt  = AVM_READ;
    write_nxt = AVM_WRITE;
    addr_nxt  = AVM_ADDR;
    be_nxt    = AVM_BYTE_EN;
    wdata_nxt = AVM_WRITEDATA;
    word_nxt  = word;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (code == CH_FF) begin
            word_nxt  = '0;
            addr_nxt  = '0;
            write_nxt = 1'b1;
            be_nxt    = 4'b1111;
            wdata_nxt = BLANK_WORD;
          end else if (overflow) begin
            word_nxt = '0;
            addr_nxt = ROW_WORDS_W;
            read_nxt = 1'b1;
            be_nxt   = 4'b1111;
          end else if (!is_move) begin
            write_nxt = 1'b1;
            addr_nxt  = cell_idx[11:2];
            be_nxt    = 4'b0001 << cell_idx[1:0];
            wdata_nxt = {4{CHAR_DATA}};
          end
        end
      end
      ST_WR_CHAR: begin
        if (!AVM_WAITREQUEST) begin
          write_nxt = 1'b0;
          if (overflow) begin
            word_nxt = '0;
            addr_nxt = ROW_WORDS_W;
            read_nxt = 1'b1;
            be_nxt   = 4'b1111;
          end
        end
      end
      ST_SC_RD: if (!AVM_WAITREQUEST) read_nxt = 1'b0;
      ST_SC_RDW: begin
        if (AVM_READDATAVALID) begin
          write_nxt = 1'b1;
          addr_nxt  = word;
          be_nxt    = 4'b1111;
          wdata_nxt = AVM_READDATA;
        end
      end
      ST_SC_WR: begin
        if (!AVM_WAITREQUEST) begin
          if (word == SCROLL_LAST) begin
            word_nxt  = CLR_FIRST;
            addr_nxt  = CLR_FIRST;
            wdata_nxt = BLANK_WORD;
          end else begin
            write_nxt = 1'b0;
            read_nxt  = 1'b1;
            word_nxt  = word + 10'd1;
            addr_nxt  = word + 10'd1 + ROW_WORDS_W;
          end
        end
      end
      ST_SC_CLR, ST_CLR: begin
        if (!AVM_WAITREQUEST) begin
          if (word == LAST_WORD) begin
            write_nxt = 1'b0;
          end else begin
            word_nxt = word + 10'd1;
            addr_nxt = word + 10'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AVM_READ      <= 1'b0;
      AVM_WRITE     <= 1'b0;
      AVM_ADDR      <= '0;
      AVM_BYTE_EN   <= '0;
      AVM_WRITEDATA <= '0;
      word          <= '0;
    end else begin
      AVM_READ      <= read_nxt;
      AVM_WRITE     <= write_nxt;
      AVM_ADDR      <= addr_nxt;
      AVM_BYTE_EN   <= be_nxt;
      AVM_WRITEDATA <= wdata_nxt;
      word          <= word_nxt;
    end
  end

endmodule

// File: tb/tb_vga_text_console_writer.sv
// Bench for vga_text_console_writer: a VRAM slave with random stalls/latency and a
// character-level screen model that predicts cursor and VRAM contents.
module tb_vga_text_console_writer;

  localparam logic [31:0] SENTINEL = 32'hC0DE_0600;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CHAR_VALID = 1'b0;
  logic        CHAR_READY;
  logic [7:0]  CHAR_DATA = 8'h00;
  logic [9:0]  AVM_ADDR;
  logic        AVM_READ;
  logic        AVM_WRITE;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic [31:0] AVM_READDATA = 32'h0;
  logic        AVM_WAITREQUEST = 1'b0;
  logic        AVM_READDATAVALID = 1'b0;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic        BUSY;

  vga_text_console_writer dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .CHAR_VALID        (CHAR_VALID),
    .CHAR_READY        (CHAR_READY),
    .CHAR_DATA         (CHAR_DATA),
    .AVM_ADDR          (AVM_ADDR),
    .AVM_READ          (AVM_READ),
    .AVM_WRITE         (AVM_WRITE),
    .AVM_BYTE_EN       (AVM_BYTE_EN),
    .AVM_WRITEDATA     (AVM_WRITEDATA),
    .AVM_READDATA      (AVM_READDATA),
    .AVM_WAITREQUEST   (AVM_WAITREQUEST),
    .AVM_READDATAVALID (AVM_READDATAVALID),
    .CURSOR_COL        (CURSOR_COL),
    .CURSOR_ROW        (CURSOR_ROW),
    .BUSY              (BUSY)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Test controls, written only by the main sequence.
  int stall_pct = 0;
  int lat_max = 1;
  bit stall_req = 0;

  // Slave state, written only by the slave process.
  logic [31:0] vram [0:600];
  bit          rd_pending = 0;
  int          rd_delay = 0;
  logic [9:0]  rd_addr = '0;
  int          stall_cnt = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          zero_writes = 0;
  int          proto_err = 0;

  // Screen model: one byte per cell, row-major, plus cursor.
  logic [7:0] m_scr [0:2399];
  int m_col = 0;
  int m_row = 0;

  // Transfers are decided at the falling edge and complete at the following rising edge.
  initial begin : slave
    for (int w = 0; w < 600; w++) vram[w] = $urandom;
    vram[600] = SENTINEL;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        rd_pending = 0;
        stall_cnt = 0;
        AVM_READDATAVALID = 1'b0;
        AVM_WAITREQUEST = 1'b0;
      end else begin
        AVM_READDATAVALID = 1'b0;
        if (rd_pending) begin
          rd_delay--;
          if (rd_delay == 0) begin
            AVM_READDATAVALID = 1'b1;
            AVM_READDATA = vram[rd_addr];
            rd_pending = 0;
          end
        end
        if (!stall_req) stall_cnt = 0;
        if (stall_req && (AVM_READ || AVM_WRITE) && stall_cnt < 3) begin
          AVM_WAITREQUEST = 1'b1;
          stall_cnt++;
        end else begin
          AVM_WAITREQUEST = (stall_pct > 0) && (int'($urandom_range(99, 0)) < stall_pct);
        end
        if (AVM_READ && AVM_WRITE) proto_err++;
        if (AVM_WRITE && !AVM_WAITREQUEST) begin
          if (AVM_ADDR >= 10'd600) proto_err++;
          else for (int k = 0; k < 4; k++)
            if (AVM_BYTE_EN[k]) vram[AVM_ADDR][8*k +: 8] = AVM_WRITEDATA[8*k +: 8];
          wr_count++;
          if (AVM_BYTE_EN == 4'hF && AVM_WRITEDATA == 32'h0) zero_writes++;
        end
        if (AVM_READ && !AVM_WAITREQUEST) begin
          if (rd_pending || AVM_ADDR >= 10'd600) proto_err++;
          rd_pending = 1;
          rd_addr = AVM_ADDR;
          rd_delay = int'($urandom_range(lat_max, 1));
          rd_count++;
        end
      end
    end
  end

  initial begin : watchdog
    #1900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_newline();
    if (m_row == 29) begin
      for (int i = 0; i < 2320; i++) m_scr[i] = m_scr[i + 80];
      for (int i = 2320; i < 2400; i++) m_scr[i] = 8'h00;
    end else begin
      m_row++;
    end
  endtask

  task automatic model_apply(input logic [7:0] b);
    case (b[6:0])
      7'h0A: begin m_col = 0; model_newline(); end
      7'h0D: m_col = 0;
      7'h08: if (m_col > 0) m_col--;
      7'h0C: begin
        foreach (m_scr[i]) m_scr[i] = 8'h00;
        m_col = 0;
        m_row = 0;
      end
      default: begin
        m_scr[m_row * 80 + m_col] = b;
        m_col++;
        if (m_col == 80) begin m_col = 0; model_newline(); end
      end
    endcase
  endtask

  function automatic logic [7:0] rand_printable();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b[6:0] == 7'h0A || b[6:0] == 7'h0D || b[6:0] == 7'h08 || b[6:0] == 7'h0C);
    return b;
  endfunction

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge CLK);
    CHAR_VALID = 1'b1;
    CHAR_DATA = b;
    while (!CHAR_READY && n < 20000) begin @(negedge CLK); n++; end
    if (!CHAR_READY) begin
      checks++; failures++;
      $display("FAIL send: CHAR_READY never rose for byte %h", b);
    end
    @(posedge CLK);
    #1;
    CHAR_VALID = 1'b0;
    CHAR_DATA = 8'($urandom);
    model_apply(b);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < 20000) begin @(negedge CLK); n++; end
    if (BUSY) begin
      checks++; failures++;
      $display("FAIL %s idle: BUSY still high after %0d cycles", name, n);
    end
  endtask

  task automatic check_screen(input string name);
    int bad = 0;
    int first = -1;
    logic [31:0] exp_w, got_w, want_w;
    got_w = '0; want_w = '0;
    wait_idle(name);
    for (int w = 0; w < 600; w++) begin
      exp_w = {m_scr[4*w+3], m_scr[4*w+2], m_scr[4*w+1], m_scr[4*w]};
      if (vram[w] !== exp_w) begin
        if (first < 0) begin first = w; got_w = vram[w]; want_w = exp_w; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s vram: %0d words differ, first word %0d got %h want %h", name, bad, first, got_w, want_w);
    end
    checks++;
    if (vram[600] !== SENTINEL) begin
      failures++;
      $display("FAIL %s ctrl_word: got %h want %h", name, vram[600], SENTINEL);
    end
    checks++;
    if (CURSOR_COL !== 7'(m_col) || CURSOR_ROW !== 5'(m_row)) begin
      failures++;
      $display("FAIL %s cursor: got (%0d,%0d) want (%0d,%0d)", name, CURSOR_COL, CURSOR_ROW, m_col, m_row);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (AVM_READ !== 1'b0 || AVM_WRITE !== 1'b0 || AVM_ADDR !== 10'd0 || AVM_BYTE_EN !== 4'd0 ||
        AVM_WRITEDATA !== 32'd0 || BUSY !== 1'b0 || CHAR_READY !== 1'b0 ||
        CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin
      failures++;
      $display("FAIL reset_state: rd=%b wr=%b addr=%0d be=%b wd=%h busy=%b ready=%b cur=(%0d,%0d) want all zero",
               AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA, BUSY, CHAR_READY, CURSOR_COL, CURSOR_ROW);
    end
    #2 RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (CHAR_READY !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b busy=%b want 1 0", CHAR_READY, BUSY);
    end
  endtask

  task automatic test_first_char();
    send(8'h41);
    @(negedge CLK);
    checks++;
    if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 10'd0 || AVM_BYTE_EN !== 4'b0001 ||
        AVM_WRITEDATA !== 32'h4141_4141 || CHAR_READY !== 1'b0) begin
      failures++;
      $display("FAIL first_write: wr=%b addr=%0d be=%b wd=%h ready=%b want 1 0 0001 41414141 0",
               AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA, CHAR_READY);
    end
    @(negedge CLK);
    checks++;
    if (CHAR_READY !== 1'b1 || AVM_WRITE !== 1'b0 || CURSOR_COL !== 7'd1 || CURSOR_ROW !== 5'd0) begin
      failures++;
      $display("FAIL first_done: ready=%b wr=%b cur=(%0d,%0d) want 1 0 (1,0)",
               CHAR_READY, AVM_WRITE, CURSOR_COL, CURSOR_ROW);
    end
    check_screen("first_char");
  endtask

  task automatic test_iv_stall();
    int wc;
    send(8'h0D); send(8'h0A); send(8'h0A);
    for (int i = 0; i < 6; i++) send(rand_printable());
    wait_idle("iv_pos");
    checks++;
    if (CURSOR_COL !== 7'd6 || CURSOR_ROW !== 5'd2) begin
      failures++;
      $display("FAIL iv_pos: cursor (%0d,%0d) want (6,2)", CURSOR_COL, CURSOR_ROW);
    end
    wc = wr_count;
    stall_req = 1;
    send(8'hC1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 10'd41 || AVM_BYTE_EN !== 4'b0100 ||
          AVM_WRITEDATA !== 32'hC1C1_C1C1 || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL iv_hold[%0d]: wr=%b addr=%0d be=%b wd=%h busy=%b want 1 41 0100 c1c1c1c1 1",
                 i, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA, BUSY);
      end
    end
    wait_idle("iv_stall");
    stall_req = 0;
    checks++;
    if (wr_count - wc != 1) begin
      failures++;
      $display("FAIL iv_write_count: got %0d want 1", wr_count - wc);
    end
    check_screen("iv_stall");
  endtask

  task automatic test_row_wrap();
    int wc, zc;
    stall_pct = 25;
    wc = wr_count; zc = zero_writes;
    send(8'h0C);
    check_screen("ff_clear");
    checks++;
    if (wr_count - wc != 600 || zero_writes - zc != 600) begin
      failures++;
      $display("FAIL ff_writes: got %0d writes %0d blank want 600 600", wr_count - wc, zero_writes - zc);
    end
    for (int i = 0; i < 80; i++) send(rand_printable());
    check_screen("row0_full");
    wc = wr_count;
    send(8'h08);
    check_screen("bs_col0");
    send(rand_printable());
    send(8'h88);
    check_screen("bs_no_erase");
    checks++;
    if (wr_count - wc != 1) begin
      failures++;
      $display("FAIL bs_writes: got %0d want 1", wr_count - wc);
    end
    send(8'h0D); send(8'h0A);
    check_screen("cr_lf");
  endtask

  task automatic test_scroll();
    int rc;
    stall_pct = 20;
    lat_max = 4;
    send(8'h0C);
    for (int i = 0; i < 2399; i++) send(rand_printable());
    check_screen("screen_full");
    rc = rd_count;
    send(8'h0A);
    check_screen("scroll_lf");
    checks++;
    if (rd_count - rc != 580) begin
      failures++;
      $display("FAIL scroll_lf_reads: got %0d want 580", rd_count - rc);
    end
    rc = rd_count;
    for (int i = 0; i < 80; i++) send(rand_printable());
    check_screen("scroll_wrap");
    checks++;
    if (rd_count - rc != 580) begin
      failures++;
      $display("FAIL scroll_wrap_reads: got %0d want 580", rd_count - rc);
    end
  endtask

  task automatic test_reset_mid_scroll();
    stall_pct = 0;
    lat_max = 1;
    for (int i = 0; i < 29; i++) send(8'h0A);
    send(8'h0A);
    repeat (50) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL mid_scroll_busy: got %b want 1", BUSY);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (AVM_READ !== 1'b0 || AVM_WRITE !== 1'b0 || BUSY !== 1'b0 || CHAR_READY !== 1'b0 ||
        CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin
      failures++;
      $display("FAIL mid_scroll_reset: rd=%b wr=%b busy=%b ready=%b cur=(%0d,%0d) want 0 0 0 0 (0,0)",
               AVM_READ, AVM_WRITE, BUSY, CHAR_READY, CURSOR_COL, CURSOR_ROW);
    end
    @(negedge CLK);
    #2 RESET = 1'b0;
    m_col = 0;
    m_row = 0;
    stall_pct = 30;
    send(8'h0C);
    check_screen("clear_after_reset");
  endtask

  initial begin : main
    #1;
    for (int w = 0; w < 600; w++)
      for (int k = 0; k < 4; k++) m_scr[4*w + k] = vram[w][8*k +: 8];
    test_reset();
    test_first_char();
    test_iv_stall();
    test_row_wrap();
    test_scroll();
    test_reset_mid_scroll();
    checks++;
    if (proto_err != 0) begin
      failures++;
      $display("FAIL avalon_protocol: %0d violations want 0", proto_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
